// File: rtl/ifu_inst_rom_responder_pkg.sv
// ---------------------------------------------------------------------------
// ifu_inst_rom_responder_pkg
//   Shared definitions for the instruction-fetch ROM/flash path:
//   - state_e        : responder FSM state encoding (3-bit)
//   - bswap32()      : reverses the byte order of a 32-bit word
//   - FLASH_BASE_ADDR / FLASH_SIZE_BYTES : default flash window. The fetch
//                      master and the arbiter address decode use the same
//                      values.
// ---------------------------------------------------------------------------
package ifu_inst_rom_responder_pkg;

  localparam logic [31:0] FLASH_BASE_ADDR  = 32'h3000_0000;
  localparam logic [31:0] FLASH_SIZE_BYTES = 32'h0100_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    READ = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ifu_inst_rom_responder.sv
// ---------------------------------------------------------------------------
// ifu_inst_rom_responder
//   Responder end of the simplified AXI-lite instruction-fetch read channel.
//   It accepts one fetch address, waits LATENCY cycles to model flash access
//   time, and issues one synchronous 64-bit read. It then returns the
//   doubleword in flash byte order. The master's per-word byte swap restores
//   the original instruction. Only one transaction is outstanding at a time.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   ifu_pc*         : address channel (pc, valid, ready)
//   ifu_inst*       : data channel (doubleword, error, valid, ready)
//   mem_ren         : one-cycle read strobe to the backing memory
//   mem_addr        : doubleword index into the memory
//   mem_rdata       : memory data, valid the cycle after mem_ren
// ---------------------------------------------------------------------------
module ifu_inst_rom_responder
  import ifu_inst_rom_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = FLASH_BASE_ADDR,
  parameter logic [31:0] SIZE_BYTES = FLASH_SIZE_BYTES,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned ADDR_W     = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ifu_pc,
  input  logic              ifu_pc_valid,
  output logic              ifu_pc_ready,
  output logic [63:0]       ifu_inst,
  output logic              ifu_inst_err,
  output logic              ifu_inst_valid,
  input  logic              ifu_inst_ready,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rdata
);

  // The window bounds use 33 bits so that BASE_ADDR + SIZE_BYTES cannot wrap.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       pc_q;
  logic [63:0]       data_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;

  logic              pc_fire;
  logic              pc_ok;
  logic [32:0]       pc_ext;
  logic [31:0]       pc_off;
  logic [ADDR_W-1:0] dw_idx;
  logic [31:0]       w_lo, w_hi;

  assign pc_fire = ifu_pc_valid & ifu_pc_ready;
  assign pc_ext  = {1'b0, ifu_pc};
  assign pc_ok   = (ifu_pc[1:0] == 2'b00) && (pc_ext >= WIN_LO) && (pc_ext < WIN_HI);

  assign pc_off  = pc_q - BASE_ADDR;
  assign dw_idx  = ADDR_W'(pc_off >> 3);

  // The word addressed by pc goes to the low half of the response. Each word
  // is byte-swapped into flash order.
  assign w_lo = pc_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign w_hi = pc_q[2] ? mem_rdata[31:0]  : mem_rdata[63:32];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal is defaulted before the case so that no path leaves
    // it unassigned; otherwise a latch would be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pc_fire) begin
          if (!pc_ok) begin
            state_d = RESP;
          end else if (LATENCY == 0) begin
            state_d = READ;
          end else begin
            state_d = WAIT;
            cnt_d   = 8'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = READ;
      end
      READ:    state_d = CAP;
      CAP:     state_d = RESP;
      RESP:    if (ifu_inst_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every sequential block uses non-blocking assignments. All registers
  // then update together at the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= 32'd0;
      data_q <= 64'd0;
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      if (pc_fire) begin
        pc_q  <= ifu_pc;
        err_q <= !pc_ok;
        if (!pc_ok) data_q <= 64'd0;
      end
      // Keep the last index so that mem_addr does not change outside READ.
      if (state_q == READ) addr_q <= dw_idx;
      if (state_q == CAP)  data_q <= {bswap32(w_hi), bswap32(w_lo)};
    end
  end

  assign ifu_pc_ready   = (state_q == IDLE);
  assign mem_ren        = (state_q == READ);
  assign mem_addr       = (state_q == READ) ? dw_idx : addr_q;
  assign ifu_inst_valid = (state_q == RESP);
  assign ifu_inst       = data_q;
  assign ifu_inst_err   = err_q;

endmodule
